// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a pending-redirect register.
// Define BRANCH_DELAY_SLOT_EN to deliver the in-flight/held instruction as a delay slot on redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       PC_STEP   = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              redir_any;
  logic [ADDR_W-1:0] redir_pc;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    // A redirect arriving this cycle is newer than the pending one.
    redir_any = redirect | pend_q;
    redir_pc  = redirect ? redirect_pc : pend_pc_q;

    if (redirect) begin
      pend_d    = 1'b1;
      pend_pc_d = redirect_pc;
    end

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pend_d = 1'b0;
          pc_d   = redir_any ? redir_pc : pc_q + ADDR_W'(PC_STEP);
`ifdef BRANCH_DELAY_SLOT_EN
          state_d   = S_HOLD;
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
`else
          if (redir_any) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_HOLD;
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
          end
`endif
        end
      end
      default: begin
        if (inst_ready) state_d = S_REQ;
        // In HOLD nothing is in flight, so a redirect retargets the next fetch at once.
        if (redirect) begin
          pend_d = 1'b0;
          pc_d   = redirect_pc;
`ifndef BRANCH_DELAY_SLOT_EN
          state_d = S_REQ;
`endif
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_VEC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign imem_req   = (state_q == S_REQ) && !reset;
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
